// File: rtl/bram_load_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : bram_load_scheduler
//  Description : Round-robin arbiter sharing one read-only parameter BRAM
//                between N_REQ burst loaders. One job runs at a time. The
//                block issues sequential reads, returns each word tagged with
//                the requester ID and word index, then pulses done.
//  Revision    : 1.0 - initial release
// ============================================================================
module bram_load_scheduler #(
    parameter int N_REQ      = 4,
    parameter int ID_W       = 2,
    parameter int W          = 8,
    parameter int ADDR_WIDTH = 18,
    parameter int LEN_W      = 10,
    parameter int RD_LAT     = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_base,
    input  logic [N_REQ*LEN_W-1:0]      req_len,
    output logic [N_REQ-1:0]            grant,
    output logic [N_REQ-1:0]            done,
    output logic                        busy,
    output logic                        bram_en,
    output logic                        bram_ren,
    output logic [ADDR_WIDTH-1:0]       bram_addr,
    input  logic [W-1:0]                bram_dout,
    output logic                        rd_valid,
    output logic [W-1:0]                rd_data,
    output logic [ID_W-1:0]             rd_id,
    output logic [LEN_W-1:0]            rd_idx,
    output logic                        rd_last
);

    // Scheduler states
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;

    // Slot index reached by stepping 'off' places upward from 'ptr', wrapping at N_REQ
    function automatic logic [ID_W-1:0] f_rr_slot(input logic [ID_W-1:0] ptr, input int off);
        return ID_W'((int'(ptr) + off) % N_REQ);
    endfunction

    // ------------------------------------------------------------------------
    // Unpack the flat per-requester buses into arrays
    // ------------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] w_base [N_REQ];
    logic [LEN_W-1:0]      w_len  [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign w_base[g] = req_base[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_len[g]  = req_len[g*LEN_W +: LEN_W];
    end

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    logic [1:0]            r_state;
    logic                  r_busy;
    logic [ID_W-1:0]       r_rr;
    logic [ID_W-1:0]       r_id;
    logic [LEN_W-1:0]      r_len;
    logic [LEN_W-1:0]      r_cnt;
    logic [N_REQ-1:0]      r_grant;
    logic [N_REQ-1:0]      r_done;
    logic                  r_en;
    logic                  r_ren;
    logic [ADDR_WIDTH-1:0] r_addr;

    // Read tags travelling alongside the BRAM latency
    logic [RD_LAT-1:0]     r_pv;
    logic [RD_LAT-1:0]     r_plast;
    logic [LEN_W-1:0]      r_pidx [RD_LAT];

    // Registered return port
    logic                  r_rd_valid;
    logic [W-1:0]          r_rd_data;
    logic [ID_W-1:0]       r_rd_id;
    logic [LEN_W-1:0]      r_rd_idx;
    logic                  r_rd_last;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic                  w_found;
    logic [ID_W-1:0]       w_pick_id;
    logic [ADDR_WIDTH-1:0] w_pick_base;
    logic [LEN_W-1:0]      w_pick_len;
    logic                  w_issue_last;
    logic                  w_tail_valid;
    logic                  w_tail_last;
    logic [LEN_W-1:0]      w_tail_idx;
    logic [ID_W-1:0]       w_rr_next;

    // First requesting slot searching upward from the round-robin pointer
    always_comb begin
        w_found     = 1'b0;
        w_pick_id   = '0;
        w_pick_base = '0;
        w_pick_len  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!w_found && req[f_rr_slot(r_rr, i)]) begin
                w_found     = 1'b1;
                w_pick_id   = f_rr_slot(r_rr, i);
                w_pick_base = w_base[f_rr_slot(r_rr, i)];
                w_pick_len  = w_len[f_rr_slot(r_rr, i)];
            end
        end
    end

    // Burst bookkeeping and the word leaving the latency pipe this cycle
    always_comb begin
        w_issue_last = (r_cnt == r_len - LEN_W'(1));
        w_tail_valid = r_pv[RD_LAT-1];
        w_tail_last  = r_pv[RD_LAT-1] & r_plast[RD_LAT-1];
        w_tail_idx   = r_pidx[RD_LAT-1];
        w_rr_next    = (r_id == ID_W'(N_REQ - 1)) ? '0 : r_id + ID_W'(1);
    end

    // ------------------------------------------------------------------------
    // Job FSM: arbitrate in IDLE, stream addresses in ISSUE, wait in DRAIN
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_busy  <= 1'b0;
            r_rr    <= '0;
            r_id    <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_grant <= '0;
            r_done  <= '0;
            r_en    <= 1'b0;
            r_ren   <= 1'b0;
            r_addr  <= '0;
        end else begin
            r_done <= '0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_found) begin
                        r_id    <= w_pick_id;
                        r_len   <= w_pick_len;
                        r_cnt   <= '0;
                        r_grant <= {{(N_REQ-1){1'b0}}, 1'b1} << w_pick_id;
                        r_en    <= 1'b1;
                        r_busy  <= 1'b1;
                        if (w_pick_len != '0) begin
                            r_ren   <= 1'b1;
                            r_addr  <= w_pick_base;
                            r_state <= c_ST_ISSUE;
                        end else begin
                            // Empty burst: straight to completion, no reads
                            r_state <= c_ST_DRAIN;
                        end
                    end
                end
                c_ST_ISSUE: begin
                    if (w_issue_last) begin
                        r_ren   <= 1'b0;
                        r_state <= c_ST_DRAIN;
                    end else begin
                        r_cnt  <= r_cnt + LEN_W'(1);
                        r_addr <= r_addr + ADDR_WIDTH'(1);
                    end
                end
                c_ST_DRAIN: begin
                    if (r_done != '0) begin
                        // Done cycle has been shown with grant still held; release now
                        r_grant <= '0;
                        r_en    <= 1'b0;
                        r_busy  <= 1'b0;
                        r_rr    <= w_rr_next;
                        r_state <= c_ST_IDLE;
                    end else if (r_len == '0 || w_tail_last) begin
                        // Aligned with the final word reaching the return port
                        r_done <= r_grant;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Delay line carrying word index and last flag for each issued read
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pv    <= '0;
            r_plast <= '0;
            for (int s = 0; s < RD_LAT; s++) begin
                r_pidx[s] <= '0;
            end
        end else begin
            r_pv[0]    <= r_ren;
            r_plast[0] <= r_ren & w_issue_last;
            r_pidx[0]  <= r_cnt;
            for (int s = 1; s < RD_LAT; s++) begin
                r_pv[s]    <= r_pv[s-1];
                r_plast[s] <= r_plast[s-1];
                r_pidx[s]  <= r_pidx[s-1];
            end
        end
    end

    // Capture returning BRAM data with its tags; idle fields are held at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_rd_id    <= '0;
            r_rd_idx   <= '0;
            r_rd_last  <= 1'b0;
        end else begin
            r_rd_valid <= w_tail_valid;
            r_rd_data  <= w_tail_valid ? bram_dout  : '0;
            r_rd_id    <= w_tail_valid ? r_id       : '0;
            r_rd_idx   <= w_tail_valid ? w_tail_idx : '0;
            r_rd_last  <= w_tail_last;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign grant     = r_grant;
    assign done      = r_done;
    assign busy      = r_busy;
    assign bram_en   = r_en;
    assign bram_ren  = r_ren;
    assign bram_addr = r_addr;
    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_data;
    assign rd_id     = r_rd_id;
    assign rd_idx    = r_rd_idx;
    assign rd_last   = r_rd_last;

endmodule
`default_nettype wire

// File: tb/tb_bram_load_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bram_load_scheduler
//  Description : Self-checking bench for bram_load_scheduler: directed job
//                table, hand-written arbitration/reset sequences, and a
//                randomized phase scored against a cycle-accurate job model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_load_scheduler;

    localparam int N_REQ  = 4;
    localparam int ID_W   = 2;
    localparam int W      = 8;
    localparam int AW     = 18;
    localparam int LEN_W  = 10;
    localparam int RD_LAT = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N_REQ-1:0]      req;
    logic [AW-1:0]         base_a [N_REQ];
    logic [LEN_W-1:0]      len_a  [N_REQ];
    logic [N_REQ*AW-1:0]   req_base;
    logic [N_REQ*LEN_W-1:0] req_len;
    logic [N_REQ-1:0]      grant;
    logic [N_REQ-1:0]      done;
    logic                  busy;
    logic                  bram_en;
    logic                  bram_ren;
    logic [AW-1:0]         bram_addr;
    logic [W-1:0]          bram_dout;
    logic                  rd_valid;
    logic [W-1:0]          rd_data;
    logic [ID_W-1:0]       rd_id;
    logic [LEN_W-1:0]      rd_idx;
    logic                  rd_last;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N_REQ; g++) begin : g_pack
        assign req_base[g*AW +: AW]       = base_a[g];
        assign req_len[g*LEN_W +: LEN_W]  = len_a[g];
    end

    bram_load_scheduler #(
        .N_REQ(N_REQ), .ID_W(ID_W), .W(W), .ADDR_WIDTH(AW), .LEN_W(LEN_W), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_base(req_base), .req_len(req_len),
        .grant(grant), .done(done), .busy(busy), .bram_en(bram_en), .bram_ren(bram_ren),
        .bram_addr(bram_addr), .bram_dout(bram_dout), .rd_valid(rd_valid), .rd_data(rd_data),
        .rd_id(rd_id), .rd_idx(rd_idx), .rd_last(rd_last)
    );

    // BRAM holding addr & 0xFF, RD_LAT cycles of read latency
    logic [W-1:0] bram_pipe [RD_LAT];
    always @(posedge clk) begin
        bram_pipe[0] <= (bram_en && bram_ren) ? bram_addr[7:0] : 8'hEE;
        for (int s = 1; s < RD_LAT; s++) bram_pipe[s] <= bram_pipe[s-1];
    end
    assign bram_dout = bram_pipe[RD_LAT-1];

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Job-level reference model: one job at a time, timing from the job's
    // grant cycle G: read k at G+k, word k returned at G+1+RD_LAT+k, done at
    // the last word (or G+1 for an empty job), idle the cycle after done.
    // ------------------------------------------------------------------------
    int  cyc = 0;
    bit  chk_on = 1'b0;
    bit  m_act = 1'b0;
    int  m_id, m_base, m_len, m_g, m_d;
    int  m_rr = 0;
    int  mk, mj;
    bit  m_found;
    logic [N_REQ-1:0] e_grant, e_done;
    logic e_busy, e_en, e_ren, e_v, e_last, a_last;
    logic [AW-1:0] e_addr, a_addr;
    logic [W-1:0] e_data, a_data;
    logic [ID_W-1:0] e_id, a_id;
    logic [LEN_W-1:0] e_idx, a_idx;
    logic [50:0] e_vec, a_vec;

    always @(negedge clk) begin
        if (m_act && cyc == m_d + 1) begin
            m_act = 1'b0;
            m_rr  = (m_id + 1) % N_REQ;
        end
        e_grant = '0; e_done = '0; e_busy = 0; e_en = 0; e_ren = 0; e_addr = '0;
        e_v = 0; e_data = '0; e_id = '0; e_idx = '0; e_last = 0;
        if (m_act && cyc >= m_g) begin
            mk = cyc - m_g;
            e_grant = N_REQ'(1 << m_id);
            e_busy  = 1; e_en = 1;
            if (mk < m_len) begin
                e_ren  = 1;
                e_addr = AW'(m_base + mk);
            end
            mj = mk - 1 - RD_LAT;
            if (mj >= 0 && mj < m_len) begin
                e_v    = 1;
                e_data = W'((m_base + mj) & 255);
                e_id   = ID_W'(m_id);
                e_idx  = LEN_W'(mj);
                e_last = (mj == m_len - 1);
            end
            if (cyc == m_d) e_done = e_grant;
        end
        if (chk_on) begin
            a_addr = e_ren ? bram_addr : '0;
            a_data = e_v ? rd_data : '0;
            a_id   = e_v ? rd_id : '0;
            a_idx  = e_v ? rd_idx : '0;
            a_last = e_v ? rd_last : 1'b0;
            e_vec = {e_grant, e_done, e_busy, e_en, e_ren, e_addr, e_v, e_data, e_id, e_idx, e_last};
            a_vec = {grant, done, busy, bram_en, bram_ren, a_addr, rd_valid, a_data, a_id, a_idx, a_last};
            n_checks++;
            if (a_vec !== e_vec) begin
                n_err++;
                $display("FAIL model cycle %0d: got %h expected %h", cyc, a_vec, e_vec);
            end
        end
        if (rst) begin
            m_act  = 1'b0;
            m_rr   = 0;
            chk_on = 1'b1;
        end else if (!m_act && req != '0) begin
            m_found = 1'b0;
            for (int i = 0; i < N_REQ; i++) begin
                if (!m_found && req[(m_rr + i) % N_REQ]) begin
                    m_found = 1'b1;
                    m_id    = (m_rr + i) % N_REQ;
                end
            end
            m_base = int'(base_a[m_id]);
            m_len  = int'(len_a[m_id]);
            m_g    = cyc + 1;
            m_d    = (m_len == 0) ? m_g + 1 : m_g + RD_LAT + m_len;
            m_act  = 1'b1;
        end
        cyc++;
    end

    // ------------------------------------------------------------------------
    // Directed single-job table: offsets counted from the request cycle T
    // ------------------------------------------------------------------------
    typedef struct {
        int id; int base; int len;
        int e_g; int e_first; int e_done; int e_words; int e_d0; int e_dl;
    } vec_t;

    vec_t vecs [5];
    vec_t v_pre;

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; req = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int seen;
        seen = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (!busy) begin seen = 1; break; end
        end
        check({nm, " idle"}, seen, 1);
        @(posedge clk); #1;
    endtask

    // Caller is just after a posedge; the request is visible from this cycle on
    task automatic run_vec(input int vi, input vec_t v);
        int g_at, g_val, f_at, d_at, d_val, words, d0, dl;
        g_at = -1; g_val = 0; f_at = -1; d_at = -1; d_val = 0; words = 0; d0 = -1; dl = -1;
        base_a[v.id] = AW'(v.base);
        len_a[v.id]  = LEN_W'(v.len);
        req = N_REQ'(1 << v.id);
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (grant != '0 && g_at < 0) begin g_at = c; g_val = int'(grant); end
            if (rd_valid) begin
                if (f_at < 0) begin f_at = c; d0 = int'(rd_data); end
                dl = int'(rd_data);
                words++;
            end
            if (done != '0) begin d_at = c; d_val = int'(done); break; end
        end
        @(posedge clk); #1 req = '0;
        repeat (2) @(posedge clk);
        #1;
        check($sformatf("vec%0d grant_lat", vi), g_at, v.e_g);
        check($sformatf("vec%0d grant_val", vi), g_val, 1 << v.id);
        check($sformatf("vec%0d first_rd_lat", vi), f_at, v.e_first);
        check($sformatf("vec%0d done_lat", vi), d_at, v.e_done);
        check($sformatf("vec%0d done_val", vi), d_val, 1 << v.id);
        check($sformatf("vec%0d words", vi), words, v.e_words);
        check($sformatf("vec%0d first_data", vi), d0, v.e_d0);
        check($sformatf("vec%0d last_data", vi), dl, v.e_dl);
    endtask

    // Watch the next n distinct grants; exp holds one-hot grants, 4 bits each, first in low nibble
    task automatic grants_seq(input string nm, input int n, input logic [31:0] exp);
        logic [N_REQ-1:0] prev;
        int got;
        prev = grant;
        got  = 0;
        for (int c = 0; c < 600 && got < n; c++) begin
            @(negedge clk);
            if (grant != '0 && grant != prev) begin
                check($sformatf("%s grant%0d", nm, got), int'(grant), int'(exp[got*4 +: 4]));
                got++;
            end
            prev = grant;
        end
        check({nm, " grant_count"}, got, n);
        @(posedge clk); #1;
    endtask

    initial begin
        vecs[0] = '{0, 147456, 8, 1, 4, 11, 8, 8'h00, 8'h07};
        vecs[1] = '{2, 77,     0, 1, -1, 2,  0, -1,    -1};
        vecs[2] = '{1, 262142, 4, 1, 4, 7,  4, 8'hFE, 8'h01};
        vecs[3] = '{3, 300,    1, 1, 4, 4,  1, 8'h2C, 8'h2C};
        vecs[4] = '{0, 1000,  13, 1, 4, 16, 13, 8'hE8, 8'hF4};
        v_pre   = '{1, 500,    3, 1, 4, 6,  3, 8'hF4, 8'hF6};

        rst = 1'b1;
        req = '0;
        for (int i = 0; i < N_REQ; i++) begin base_a[i] = '0; len_a[i] = '0; end
        do_reset();

        // Reset state
        @(negedge clk);
        check("reset outputs", int'({grant, done, busy, bram_en, bram_ren, rd_valid, rd_last}), 0);
        check("reset addr", int'(bram_addr), 0);
        @(posedge clk); #1;

        // Single jobs, including empty burst and address wrap
        for (int v = 0; v < 5; v++) run_vec(v, vecs[v]);

        // All four requesting: strict rotation
        do_reset();
        for (int i = 0; i < N_REQ; i++) begin base_a[i] = AW'(i * 64); len_a[i] = LEN_W'(4); end
        req = 4'b1111;
        grants_seq("rr_all", 8, 32'h84218421);
        req = '0;
        wait_idle("rr_all");

        // Reset during the third read of a len=8 job
        run_vec(5, v_pre);
        base_a[2] = '0; len_a[2] = LEN_W'(8);
        req = 4'b0100;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst ren", int'(bram_ren), 1);
        check("mid_rst addr", int'(bram_addr), 2);
        @(posedge clk); #1;
        rst = 1'b0;
        base_a[0] = AW'(20); len_a[0] = LEN_W'(2);
        req = 4'b1111;
        @(negedge clk);
        check("post_rst outputs", int'({grant, done, busy, bram_en, bram_ren, rd_valid}), 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("post_rst grant", int'(grant), 1);
        @(posedge clk); #1 req = '0;
        wait_idle("post_rst");

        // req0 held, req3 raised mid-job: 3 wins next, then 0
        do_reset();
        base_a[0] = AW'(10); len_a[0] = LEN_W'(6);
        base_a[3] = AW'(90); len_a[3] = LEN_W'(2);
        req = 4'b0001;
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_req first grant", int'(grant), 1);
        @(posedge clk); #1 req = 4'b1001;
        grants_seq("mid_req", 2, 32'h00000018);
        req = '0;
        wait_idle("mid_req");

        // Randomized traffic scored by the model
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 399) == 0);
            for (int i = 0; i < N_REQ; i++) begin
                if ($urandom_range(0, 5) == 0) req[i] = ~req[i];
                base_a[i] = AW'($urandom);
                len_a[i]  = ($urandom_range(0, 4) == 0) ? '0 : LEN_W'($urandom_range(1, 20));
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
        req = '0;
        repeat (40) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
